// File: rtl/gemm_seq_pkg.sv
// Shared constants and FSM encoding for the GEMM sequencer and its helpers.
package gemm_seq_pkg;

    localparam int ACC_WIDTH  = 32;
    localparam int INP_DEPTH  = 16;
    localparam int AT_WIDTH   = ACC_WIDTH * INP_DEPTH;
    localparam int INP_ADDR_W = 8;
    localparam int WGT_ADDR_W = 8;
    localparam int ACC_ADDR_W = 8;
    localparam int CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gemm_seq_addr_gen.sv
// Base + stride address counter: load captures base and stride, each advance
// adds the stride. The adder truncates, so addresses wrap modulo 2^ADDR_W.
module gemm_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;

    // Load base/stride at launch, otherwise step by the stride on each issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_stride <= '0;
        end else if (i_load) begin
            r_addr   <= i_base;
            r_stride <= i_stride;
        end else if (i_advance) begin
            r_addr   <= r_addr + r_stride;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/gemm_seq.sv
// GEMM sequencer: walks N iterations, issuing input/weight/accumulator reads,
// steering the accumulator operand into gemm_op and writing its result back.
// Back-to-back writes to the same accumulator address are forwarded because
// the BRAM returns stale data when a read collides with the previous write.
module gemm_seq
    import gemm_seq_pkg::*;
#(
    parameter int P_ACC_WIDTH  = ACC_WIDTH,
    parameter int P_INP_DEPTH  = INP_DEPTH,
    parameter int P_INP_ADDR_W = INP_ADDR_W,
    parameter int P_WGT_ADDR_W = WGT_ADDR_W,
    parameter int P_ACC_ADDR_W = ACC_ADDR_W,
    parameter int P_CNT_WIDTH  = CNT_WIDTH,
    parameter int P_AT_WIDTH   = P_ACC_WIDTH * P_INP_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [P_CNT_WIDTH-1:0]  i_cfg_count,
    input  logic [P_INP_ADDR_W-1:0] i_cfg_inp_base,
    input  logic [P_INP_ADDR_W-1:0] i_cfg_inp_stride,
    input  logic [P_WGT_ADDR_W-1:0] i_cfg_wgt_base,
    input  logic [P_WGT_ADDR_W-1:0] i_cfg_wgt_stride,
    input  logic [P_ACC_ADDR_W-1:0] i_cfg_acc_base,
    input  logic [P_ACC_ADDR_W-1:0] i_cfg_acc_stride,
    input  logic                    i_cfg_reset_acc,
    output logic                    o_inp_en,
    output logic [P_INP_ADDR_W-1:0] o_inp_addr,
    output logic                    o_wgt_en,
    output logic [P_WGT_ADDR_W-1:0] o_wgt_addr,
    output logic                    o_acc_ren,
    output logic [P_ACC_ADDR_W-1:0] o_acc_raddr,
    input  logic [P_AT_WIDTH-1:0]   i_acc_rdata,
    output logic [P_AT_WIDTH-1:0]   o_gemm_a,
    input  logic [P_AT_WIDTH-1:0]   i_gemm_o,
    output logic                    o_acc_we,
    output logic [P_ACC_ADDR_W-1:0] o_acc_waddr,
    output logic [P_AT_WIDTH-1:0]   o_acc_wdata,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = P_CNT_WIDTH'(1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [P_CNT_WIDTH-1:0]    r_count;
    logic [P_CNT_WIDTH-1:0]    r_iter;
    logic                      r_reset_acc;
    logic [P_ACC_ADDR_W-1:0]   r_prev_acc_addr;
    logic                      r_we;
    logic [P_ACC_ADDR_W-1:0]   r_waddr;
    logic                      r_fwd;
    logic [P_AT_WIDTH-1:0]     r_fwd_data;

    logic                      w_accept;
    logic                      w_issue;
    logic                      w_last;
    logic [P_INP_ADDR_W-1:0]   w_inp_addr;
    logic [P_WGT_ADDR_W-1:0]   w_wgt_addr;
    logic [P_ACC_ADDR_W-1:0]   w_acc_addr;
    logic [P_AT_WIDTH-1:0]     w_gemm_a;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_issue  = (r_state == S_RUN);
    assign w_last   = (r_iter == (r_count - CNT_ONE));

    gemm_addr_gen #(.ADDR_W(P_INP_ADDR_W)) u_inp_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_base    (i_cfg_inp_base),
        .i_stride  (i_cfg_inp_stride),
        .i_advance (w_issue),
        .o_addr    (w_inp_addr)
    );

    gemm_addr_gen #(.ADDR_W(P_WGT_ADDR_W)) u_wgt_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_base    (i_cfg_wgt_base),
        .i_stride  (i_cfg_wgt_stride),
        .i_advance (w_issue),
        .o_addr    (w_wgt_addr)
    );

    gemm_addr_gen #(.ADDR_W(P_ACC_ADDR_W)) u_acc_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_base    (i_cfg_acc_base),
        .i_stride  (i_cfg_acc_stride),
        .i_advance (w_issue),
        .o_addr    (w_acc_addr)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs; a zero count skips straight to DONE.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_inp_en     = 1'b0;
        o_wgt_en     = 1'b0;
        o_acc_ren    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_cfg_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                o_busy    = 1'b1;
                o_inp_en  = 1'b1;
                o_wgt_en  = 1'b1;
                o_acc_ren = 1'b1;
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_busy       = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Latch the run configuration at launch and count issued iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_iter      <= '0;
            r_reset_acc <= 1'b0;
        end else if (w_accept) begin
            r_count     <= i_cfg_count;
            r_iter      <= '0;
            r_reset_acc <= i_cfg_reset_acc;
        end else if (w_issue) begin
            r_iter      <= r_iter + CNT_ONE;
        end
    end

    // Delay the issued accumulator address to the write cycle and flag
    // consecutive same-address iterations for forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we            <= 1'b0;
            r_waddr         <= '0;
            r_prev_acc_addr <= '0;
            r_fwd           <= 1'b0;
        end else begin
            r_we  <= w_issue;
            r_fwd <= w_issue && (r_iter != '0) && (w_acc_addr == r_prev_acc_addr);
            if (w_issue) begin
                r_waddr         <= w_acc_addr;
                r_prev_acc_addr <= w_acc_addr;
            end
        end
    end

    // Hold the last written result for use by a following same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_data <= '0;
        end else if (r_we) begin
            r_fwd_data <= i_gemm_o;
        end
    end

    // Accumulator operand: zero unless writing and accumulating.
    always_comb begin
        w_gemm_a = '0;
        if (r_we && !r_reset_acc) begin
            w_gemm_a = r_fwd ? r_fwd_data : i_acc_rdata;
        end
    end

    assign o_inp_addr  = w_inp_addr;
    assign o_wgt_addr  = w_wgt_addr;
    assign o_acc_raddr = w_acc_addr;
    assign o_gemm_a    = w_gemm_a;
    assign o_acc_we    = r_we;
    assign o_acc_waddr = r_waddr;
    assign o_acc_wdata = i_gemm_o;

endmodule

// File: tb/tb_gemm_seq.sv
// Directed bench for gemm_seq with behavioural BRAMs and a lane-wise gemm_op model.
module tb_gemm_seq;
    import gemm_seq_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [CNT_WIDTH-1:0]  cfg_count;
    logic [7:0]            cfg_inp_base, cfg_inp_stride;
    logic [7:0]            cfg_wgt_base, cfg_wgt_stride;
    logic [7:0]            cfg_acc_base, cfg_acc_stride;
    logic                  cfg_reset_acc;
    logic                  inp_en, wgt_en, acc_ren, acc_we, busy, done;
    logic [7:0]            inp_addr, wgt_addr, acc_raddr, acc_waddr;
    logic [AT_WIDTH-1:0]   acc_rdata, gemm_a, gemm_o, acc_wdata;

    logic [7:0]            inp_mem [256];
    logic [7:0]            wgt_mem [256];
    logic [AT_WIDTH-1:0]   acc_mem [256];
    logic [7:0]            inp_q, wgt_q;

    int n_vec = 0;
    int n_err = 0;

    gemm_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .i_cfg_count      (cfg_count),
        .i_cfg_inp_base   (cfg_inp_base),
        .i_cfg_inp_stride (cfg_inp_stride),
        .i_cfg_wgt_base   (cfg_wgt_base),
        .i_cfg_wgt_stride (cfg_wgt_stride),
        .i_cfg_acc_base   (cfg_acc_base),
        .i_cfg_acc_stride (cfg_acc_stride),
        .i_cfg_reset_acc  (cfg_reset_acc),
        .o_inp_en         (inp_en),
        .o_inp_addr       (inp_addr),
        .o_wgt_en         (wgt_en),
        .o_wgt_addr       (wgt_addr),
        .o_acc_ren        (acc_ren),
        .o_acc_raddr      (acc_raddr),
        .i_acc_rdata      (acc_rdata),
        .o_gemm_a         (gemm_a),
        .i_gemm_o         (gemm_o),
        .o_acc_we         (acc_we),
        .o_acc_waddr      (acc_waddr),
        .o_acc_wdata      (acc_wdata),
        .o_busy           (busy),
        .o_done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: registered reads, read-during-write returns old data.
    always @(posedge clk) begin
        if (inp_en)  inp_q     <= inp_mem[inp_addr];
        if (wgt_en)  wgt_q     <= wgt_mem[wgt_addr];
        if (acc_ren) acc_rdata <= acc_mem[acc_raddr];
        if (acc_we)  acc_mem[acc_waddr] <= acc_wdata;
    end

    // gemm_op model: each lane adds INP_DEPTH products of the scalar input and weight.
    always_comb begin
        gemm_o = '0;
        for (int l = 0; l < INP_DEPTH; l++) begin
            gemm_o[l*ACC_WIDTH +: ACC_WIDTH] = gemm_a[l*ACC_WIDTH +: ACC_WIDTH]
                + 32'(INP_DEPTH) * 32'(inp_q) * 32'(wgt_q);
        end
    end

    function automatic logic [AT_WIDTH-1:0] splat(input logic [31:0] v);
        return {INP_DEPTH{v}};
    endfunction

    // Drive a configuration with a one-cycle start; returns at the negedge of cycle 1.
    task automatic launch(input int n, input int ib, input int is, input int wb, input int ws,
                          input int ab, input int as, input logic racc);
        @(negedge clk);
        cfg_count      = CNT_WIDTH'(n);
        cfg_inp_base   = 8'(ib);
        cfg_inp_stride = 8'(is);
        cfg_wgt_base   = 8'(wb);
        cfg_wgt_stride = 8'(ws);
        cfg_acc_base   = 8'(ab);
        cfg_acc_stride = 8'(as);
        cfg_reset_acc  = racc;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({inp_en, wgt_en, acc_ren, acc_we, busy, done} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_strobes got=%b exp=000000", {inp_en, wgt_en, acc_ren, acc_we, busy, done});
        end
        n_vec++;
        if ({inp_addr, wgt_addr, acc_raddr, acc_waddr} !== 32'h0 || gemm_a !== '0) begin
            n_err++;
            $display("FAIL reset_addr got=%h exp=0", {inp_addr, wgt_addr, acc_raddr, acc_waddr});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got busy=%b done=%b exp=0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        for (int a = 0; a < 3; a++) begin
            inp_mem[a] <= 8'(a + 1);
            wgt_mem[a] <= 8'd2;
            acc_mem[a] <= splat(32'd7);
        end
        launch(3, 0, 1, 0, 1, 0, 1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            n_vec++;
            if ({inp_en, wgt_en, acc_ren} !== {3{c <= 3}}) begin
                n_err++;
                $display("FAIL basic_en c=%0d got=%b exp=%b", c, {inp_en, wgt_en, acc_ren}, {3{c <= 3}});
            end
            if (c <= 3) begin
                n_vec++;
                if (inp_addr !== 8'(c - 1) || wgt_addr !== 8'(c - 1) || acc_raddr !== 8'(c - 1)) begin
                    n_err++;
                    $display("FAIL basic_raddr c=%0d got=%0d/%0d/%0d exp=%0d", c, inp_addr, wgt_addr, acc_raddr, c - 1);
                end
            end
            n_vec++;
            if (acc_we !== (c >= 2 && c <= 4) || (acc_we && acc_waddr !== 8'(c - 2))) begin
                n_err++;
                $display("FAIL basic_we c=%0d got we=%b addr=%0d exp we=%b addr=%0d", c, acc_we, acc_waddr, (c >= 2 && c <= 4), c - 2);
            end
            n_vec++;
            if (done !== (c == 5) || busy !== (c <= 4)) begin
                n_err++;
                $display("FAIL basic_ctl c=%0d got done=%b busy=%b exp done=%b busy=%b", c, done, busy, c == 5, c <= 4);
            end
            n_vec++;
            if (gemm_a !== '0) begin
                n_err++;
                $display("FAIL basic_gemm_a c=%0d got=%h exp=0", c, gemm_a[31:0]);
            end
            @(negedge clk);
        end
        for (int a = 0; a < 3; a++) begin
            n_vec++;
            if (acc_mem[a] !== splat(32'(32 * (a + 1)))) begin
                n_err++;
                $display("FAIL basic_acc a=%0d got=%0d exp=%0d", a, acc_mem[a][31:0], 32 * (a + 1));
            end
        end
    endtask

    task automatic test_forward();
        inp_mem[20] <= 8'd1;
        wgt_mem[20] <= 8'd2;
        acc_mem[5]  <= splat(32'd10);
        launch(4, 20, 0, 20, 0, 5, 0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            n_vec++;
            if (acc_we !== (c >= 2 && c <= 5) || (acc_we && acc_waddr !== 8'd5)) begin
                n_err++;
                $display("FAIL fwd_we c=%0d got we=%b addr=%0d exp we=%b addr=5", c, acc_we, acc_waddr, (c >= 2 && c <= 5));
            end
            n_vec++;
            if (c >= 2 && c <= 5) begin
                if (gemm_a !== splat(32'(10 + 32 * (c - 2)))) begin
                    n_err++;
                    $display("FAIL fwd_gemm_a c=%0d got=%0d exp=%0d", c, gemm_a[31:0], 10 + 32 * (c - 2));
                end
            end else if (gemm_a !== '0) begin
                n_err++;
                $display("FAIL fwd_gemm_a_idle c=%0d got=%0d exp=0", c, gemm_a[31:0]);
            end
            n_vec++;
            if (done !== (c == 6)) begin
                n_err++;
                $display("FAIL fwd_done c=%0d got=%b exp=%b", c, done, c == 6);
            end
            @(negedge clk);
        end
        n_vec++;
        if (acc_mem[5] !== splat(32'd138)) begin
            n_err++;
            $display("FAIL fwd_acc got=%0d exp=138", acc_mem[5][31:0]);
        end
    endtask

    task automatic test_zero_count();
        launch(0, 0, 1, 0, 1, 0, 1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            n_vec++;
            if ({inp_en, wgt_en, acc_ren, acc_we, busy} !== 5'b0 || done !== (c == 1)) begin
                n_err++;
                $display("FAIL zero_count c=%0d got strobes=%b done=%b exp strobes=00000 done=%b",
                         c, {inp_en, wgt_en, acc_ren, acc_we, busy}, done, c == 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] tbl [4];
        tbl = '{8'd254, 8'd255, 8'd0, 8'd1};
        launch(4, 254, 1, 0, 1, 100, 1, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) begin
                n_vec++;
                if (inp_en !== 1'b1 || inp_addr !== tbl[c-1]) begin
                    n_err++;
                    $display("FAIL wrap_inp_addr c=%0d got en=%b addr=%0d exp en=1 addr=%0d", c, inp_en, inp_addr, tbl[c-1]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n_we = 0;
        int n_done = 0;
        int done_c = -1;
        launch(5, 0, 1, 0, 1, 40, 1, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) begin
                cfg_count = CNT_WIDTH'(2);
                start     = 1'b1;
            end else begin
                start     = 1'b0;
            end
            if (acc_we) n_we++;
            if (done) begin
                n_done++;
                done_c = c;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_vec++;
        if (n_we != 5) begin
            n_err++;
            $display("FAIL b2b_writes got=%0d exp=5", n_we);
        end
        n_vec++;
        if (n_done != 1 || done_c != 7) begin
            n_err++;
            $display("FAIL b2b_done got count=%0d cycle=%0d exp count=1 cycle=7", n_done, done_c);
        end
    endtask

    task automatic test_mid_reset();
        int n_we = 0;
        int n_done = 0;
        launch(6, 0, 1, 0, 1, 50, 1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            if (acc_we) n_we++;
            if (c < 3) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({inp_en, wgt_en, acc_ren, acc_we, busy, done} !== 6'b0 || gemm_a !== '0
            || {inp_addr, acc_raddr, acc_waddr} !== 24'h0) begin
            n_err++;
            $display("FAIL midrst_outputs got=%b exp=000000", {inp_en, wgt_en, acc_ren, acc_we, busy, done});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (acc_we) n_we++;
            if (done) n_done++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (acc_we) n_we++;
            if (done) n_done++;
        end
        n_vec++;
        if (n_we > 2 || n_done != 0) begin
            n_err++;
            $display("FAIL midrst_aborted got writes=%0d dones=%0d exp writes<=2 dones=0", n_we, n_done);
        end
        acc_mem[0] <= '0;
        acc_mem[1] <= '0;
        n_we = 0;
        n_done = 0;
        launch(2, 0, 1, 0, 1, 0, 1, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            if (acc_we) n_we++;
            if (done) begin
                n_done++;
                n_vec++;
                if (c != 4) begin
                    n_err++;
                    $display("FAIL midrst_rerun_done got cycle=%0d exp=4", c);
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (n_we != 2 || n_done != 1) begin
            n_err++;
            $display("FAIL midrst_rerun got writes=%0d dones=%0d exp 2 1", n_we, n_done);
        end
        n_vec++;
        if (acc_mem[0] !== splat(32'd32) || acc_mem[1] !== splat(32'd64)) begin
            n_err++;
            $display("FAIL midrst_rerun_acc got=%0d,%0d exp=32,64", acc_mem[0][31:0], acc_mem[1][31:0]);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        cfg_count      = '0;
        cfg_inp_base   = '0;
        cfg_inp_stride = '0;
        cfg_wgt_base   = '0;
        cfg_wgt_stride = '0;
        cfg_acc_base   = '0;
        cfg_acc_stride = '0;
        cfg_reset_acc  = 1'b0;
        inp_q          = '0;
        wgt_q          = '0;
        acc_rdata      = '0;
        for (int a = 0; a < 256; a++) begin
            inp_mem[a] = '0;
            wgt_mem[a] = '0;
            acc_mem[a] = '0;
        end
        test_reset();
        test_basic();
        test_forward();
        test_zero_count();
        test_addr_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gemm_seq.md
Name: gemm_seq

Overview:
Sequencer that drives the combinational gemm_op core across a loop of N iterations. It issues reads to the input, weight and accumulator BRAMs and feeds the accumulator operand (a_tensor) to gemm_op. It writes gemm_op's o_tensor back to the accumulator BRAM. It sits between the micro-op/instruction front end (upstream) and the bram_sp memories plus gemm_op (downstream). The i_tensor and w_tensor data paths run straight from BRAM to gemm_op; this block owns addressing, timing, read-after-write forwarding and completion.

Parameters:
ACC_WIDTH, 32, accumulator lane width
INP_DEPTH, 16, lanes per tensor; accumulator tensor width AT_WIDTH = ACC_WIDTH*INP_DEPTH
INP_ADDR_W, 8, input BRAM address width
WGT_ADDR_W, 8, weight BRAM address width
ACC_ADDR_W, 8, accumulator BRAM address width
CNT_WIDTH, 16, iteration count width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle launch pulse; sampled only in IDLE
cfg_count  in  CNT_WIDTH  iterations N
cfg_inp_base / cfg_inp_stride  in  INP_ADDR_W  input start address / per-iteration increment
cfg_wgt_base / cfg_wgt_stride  in  WGT_ADDR_W  weight start address / increment
cfg_acc_base / cfg_acc_stride  in  ACC_ADDR_W  accumulator start address / increment
cfg_reset_acc  in  1  1: a_tensor forced to zero (overwrite, no accumulate)
inp_en, inp_addr  out  1, INP_ADDR_W  input BRAM read
wgt_en, wgt_addr  out  1, WGT_ADDR_W  weight BRAM read
acc_ren, acc_raddr  out  1, ACC_ADDR_W  accumulator read port
acc_rdata  in  AT_WIDTH  accumulator read data (1-cycle latency)
gemm_a  out  AT_WIDTH  a_tensor to gemm_op
gemm_o  in  AT_WIDTH  o_tensor from gemm_op
acc_we, acc_waddr, acc_wdata  out  1, ACC_ADDR_W, AT_WIDTH  accumulator write port; acc_wdata = gemm_o
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): state IDLE; all enables, busy and done are 0; all addresses are 0; forwarding register is 0. Reset mid-run aborts immediately; no further write is issued.
- States: IDLE -> (start) RUN, or -> DONE if cfg_count==0. RUN -> DRAIN after the issue of iteration N-1. DRAIN -> DONE. DONE -> IDLE.
- cfg_* are latched on the start cycle. start outside IDLE is ignored.
- Timing for a start at cycle 0:
  - Iteration k (0..N-1) issues its read in cycle k+1: inp_en=wgt_en=acc_ren=1 with the current addresses.
  - acc_we for iteration k is asserted in cycle k+2, with acc_waddr equal to that iteration's read address, carried through a delay register.
  - done pulses in cycle N+2. busy is high for cycles 1..N+1.
  - With N=0: done pulses in cycle 1; no enables or writes occur.
- Addresses start at base and advance by adding stride after each issue, modulo 2^ADDR_W (wrap, no error).
- gemm_a in a write cycle:
  - 0 if cfg_reset_acc.
  - Otherwise, if fwd=1: the forwarding register, which holds the acc_wdata written in the previous cycle.
  - Otherwise: acc_rdata.
- fwd is registered at issue time: 1 when k>0 and the issued acc address equals the previous iteration's acc address. This covers the BRAM read-during-write hazard when consecutive iterations accumulate to the same address (e.g. stride 0).
- gemm_a is 0 outside write cycles.
- Arithmetic: address adders truncate; the data path contains no arithmetic (gemm_op owns MAC width and wrap).

Decomposition:
- Shared package: tensor-width constants (INP/WGT/ACC widths, INP_DEPTH, AT_WIDTH) and state encoding (IDLE, RUN, DRAIN, DONE).
- One natural sub-module: gemm_addr_gen, a base+stride accumulating counter with load/advance. Instantiate it three times (inp, wgt, acc).

Test Plan:
- N=3, bases 0/0/0, strides 1/1/1, reset_acc=1 -> reads at addr 0,1,2 in cycles 1-3; acc_we in cycles 2-4 to addr 0,1,2; done in cycle 5; acc holds gemm(i,w).
- N=4, acc_stride=0, acc[5] preloaded with 10 in every lane, inp/wgt giving lane product 2, reset_acc=0 -> every write hits addr 5; fwd used for k=1..3; final acc[5] lanes = 10 + 4*(16*2) = 138.
- N=0 start -> done in cycle 1, busy never high, no enable or write strobes.
- inp_base=254, inp_stride=1, N=4, INP_ADDR_W=8 -> inp_addr sequence 254, 255, 0, 1.
- start pulsed again in cycle 2 of an N=5 run -> ignored; exactly 5 writes, single done in cycle 7.
- rst asserted in cycle 3 of an N=6 run -> outputs zero immediately, at most writes for k=0,1 observed, no done; new start afterwards runs cleanly.
